time_adjust_ctrl: RTL

TIME_ADJUST_CTRL -- requirements
Module: time_adjust_ctrl

---
 rtl/time_pkg.sv | 23 ++
 rtl/key_debounce.sv | 61 ++++++
 rtl/time_adjust_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/time_pkg.sv
// Shared definitions for the time-adjust controller: FSM states, digit field
// indices and default cycle counts. Optional build macro used by the
// controller: TIME_ADJUST_AUTO_REPEAT_EN.
package time_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_IDLE  = 2'd1,
    SET_PULSE = 2'd2
  } state_e;

  // Field indices on the select bus (0/1 are the ms digits, never adjustable)
  localparam logic [3:0] SEL_SEC_L = 4'd2;
  localparam logic [3:0] SEL_MAX   = 4'd15;

  // Defaults for a 50 MHz clock
  localparam int DEB_CYC_DEF        = 500_000;
  localparam int TIMEOUT_CYC_DEF    = 500_000_000;
  localparam int PULSE_CYC_DEF      = 4;
  localparam int RPT_DELAY_CYC_DEF  = 25_000_000;
  localparam int RPT_PERIOD_CYC_DEF = 5_000_000;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchroniser, counter debounce and a 1-cycle press
// strobe on the debounced falling edge. With TIME_ADJUST_AUTO_REPEAT_EN the
// debounced level is also exported as 'held'.
module key_debounce
  import time_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
  output logic held,
`endif
  output logic press
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Count consecutive samples that disagree with the debounced level; flip on the last one
  always_comb begin
    sync_d   = {sync_q[0], key_n};
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        stable_d = sync_q[1];
        press_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset to the released (high) level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
  assign held  = ~stable_q;
`endif

endmodule

// File: rtl/time_adjust_ctrl.sv
// Manual time-set controller: four debounced keys drive a RUN / SET_IDLE /
// SET_PULSE FSM that selects a digit field and emits fixed-width add/clr
// pulses. Define TIME_ADJUST_AUTO_REPEAT_EN for add-key auto-repeat.
module time_adjust_ctrl
  import time_pkg::*;
#(
  parameter int DEB_CYC        = DEB_CYC_DEF,
  parameter int TIMEOUT_CYC    = TIMEOUT_CYC_DEF,
  parameter int PULSE_CYC      = PULSE_CYC_DEF,
  parameter int RPT_DELAY_CYC  = RPT_DELAY_CYC_DEF,
  parameter int RPT_PERIOD_CYC = RPT_PERIOD_CYC_DEF
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_next,
  input  logic       key_add,
  input  logic       key_clr,
  output logic       adjust,
  output logic [3:0] select,
  output logic       add,
  output logic       clr,
  output logic       in_set
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  logic mode_p, next_p, add_p, clr_p;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (.clk(CLOCK_50), .rst_n(rst_n), .key_n(key_mode), .press(mode_p));
  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_next (.clk(CLOCK_50), .rst_n(rst_n), .key_n(key_next), .press(next_p));
  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_clr  (.clk(CLOCK_50), .rst_n(rst_n), .key_n(key_clr),  .press(clr_p));

  state_e        state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] to_q, to_d;
  logic          pend_q, pend_d;
  logic          is_clr_q, is_clr_d;
  logic          add_ev, clr_ev, evt_any;

`ifdef TIME_ADJUST_AUTO_REPEAT_EN
  localparam int RMAX = (RPT_DELAY_CYC > RPT_PERIOD_CYC) ? RPT_DELAY_CYC : RPT_PERIOD_CYC;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic          add_held;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rph_q, rph_d;
  logic          rpt_ev;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_add (.clk(CLOCK_50), .rst_n(rst_n), .key_n(key_add), .held(add_held), .press(add_p));

  // Hold timer for add: first repeat after RPT_DELAY_CYC, then every RPT_PERIOD_CYC
  always_comb begin
    rcnt_d = rcnt_q;
    rph_d  = rph_q;
    rpt_ev = 1'b0;
    if (state_q == RUN || !add_held || add_p) begin
      rcnt_d = '0;
      rph_d  = 1'b0;
    end else if (rph_q ? (rcnt_q == RW'(RPT_PERIOD_CYC - 1)) : (rcnt_q == RW'(RPT_DELAY_CYC - 1))) begin
      rpt_ev = 1'b1;
      rcnt_d = '0;
      rph_d  = 1'b1;
    end else begin
      rcnt_d = rcnt_q + 1'b1;
    end
  end

  // Repeat timer registers
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      rph_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rph_q  <= rph_d;
    end
  end

  assign add_ev = add_p | rpt_ev;
`else
  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_add (.clk(CLOCK_50), .rst_n(rst_n), .key_n(key_add), .press(add_p));

  assign add_ev = add_p;
`endif

  assign clr_ev  = clr_p;
  assign evt_any = mode_p | next_p | add_ev | clr_ev;

  // Next-state: field selection, pulse timing, idle timeout and the deferred mode press
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pcnt_d   = pcnt_q;
    to_d     = to_q;
    pend_d   = pend_q;
    is_clr_d = is_clr_q;
    case (state_q)
      RUN: begin
        to_d   = '0;
        pend_d = 1'b0;
        if (mode_p) begin
          state_d = SET_IDLE;
          sel_d   = SEL_SEC_L;
        end
      end
      SET_IDLE: begin
        if (mode_p) begin
          state_d = RUN;
        end else begin
          if (next_p) sel_d = (sel_q == SEL_MAX) ? SEL_SEC_L : sel_q + 4'd1;
          // clr wins when both arrive together
          if (add_ev || clr_ev) begin
            state_d  = SET_PULSE;
            pcnt_d   = '0;
            is_clr_d = clr_ev;
          end
          if (evt_any)                          to_d = '0;
          else if (to_q == TW'(TIMEOUT_CYC - 1)) state_d = RUN;
          else                                  to_d = to_q + 1'b1;
        end
      end
      SET_PULSE: begin
        to_d = '0;
        if (mode_p) pend_d = 1'b1;
        if (pcnt_q == PW'(PULSE_CYC - 1)) begin
          state_d = (pend_q || mode_p) ? RUN : SET_IDLE;
          pend_d  = 1'b0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Controller registers
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q  <= RUN;
      sel_q    <= SEL_SEC_L;
      pcnt_q   <= '0;
      to_q     <= '0;
      pend_q   <= 1'b0;
      is_clr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pcnt_q   <= pcnt_d;
      to_q     <= to_d;
      pend_q   <= pend_d;
      is_clr_q <= is_clr_d;
    end
  end

  assign adjust = (state_q == RUN);
  assign in_set = ~adjust;
  assign select = sel_q;
  assign add    = (state_q == SET_PULSE) & ~is_clr_q;
  assign clr    = (state_q == SET_PULSE) &  is_clr_q;

endmodule
